// File: rtl/pid_hdng_pkg.sv
// pid_hdng_pkg: default widths, output scaling and signed saturation helper
// shared by the pid_hdng_ctrl heading controller.
`default_nettype none

package pid_hdng_pkg;

    localparam int DEF_HDNG_W   = 12;
    localparam int DEF_ERR_W    = 10;
    localparam int DEF_SPD_W    = 11;
    localparam int DEF_OUT_W    = 12;
    localparam int DEF_I_SHIFT  = 4;
    localparam int DEF_D_DEPTH  = 2;
    localparam int DEF_AT_THR   = 30;
    localparam int DEF_SLEW_MAX = 16;

    // PID sum is scaled by 1/8 before becoming the steering target.
    localparam int OUT_SHIFT = 3;

    function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                                 input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi)
            sat_s = hi;
        else if (value < lo)
            sat_s = lo;
        else
            sat_s = value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pid_hdng_integ.sv
// pid_hdng_integ: heading-error integrator with clear-on-idle, overflow hold
// and arithmetic-shift I-term extraction.
`default_nettype none

module pid_hdng_integ
    import pid_hdng_pkg::*;
#(
    parameter int ERR_W   = DEF_ERR_W,
    parameter int I_SHIFT = DEF_I_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving_i,
    input  logic                    hdng_vld_i,
    input  logic signed [ERR_W-1:0] err_i,
    output logic signed [ERR_W+5:0] i_term_o
);

    localparam int IW = ERR_W + 6;

    logic signed [IW-1:0] integ_q;
    logic signed [IW-1:0] integ_d;
    logic signed [IW:0]   sum;
    logic                 ovf;

    // One guard bit exposes overflow as a disagreement of the top two bits.
    assign sum = (IW+1)'(integ_q) + (IW+1)'(err_i);
    assign ovf = sum[IW] ^ sum[IW-1];

    always_comb begin
        integ_d = integ_q;
        if (!moving_i)
            integ_d = '0;
        else if (hdng_vld_i && !ovf)
            integ_d = sum[IW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            integ_q <= '0;
        else
            integ_q <= integ_d;
    end

    assign i_term_o = integ_q >>> I_SHIFT;

endmodule

`default_nettype wire

// File: rtl/pid_hdng_ctrl.sv
// pid_hdng_ctrl: heading PID controller producing saturated left/right motor speeds.
// Optional slew limiting of the PID output is enabled with PID_HDNG_SLEW_EN.
`default_nettype none

module pid_hdng_ctrl
    import pid_hdng_pkg::*;
#(
    parameter int HDNG_W   = DEF_HDNG_W,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int SPD_W    = DEF_SPD_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int I_SHIFT  = DEF_I_SHIFT,
    parameter int D_DEPTH  = DEF_D_DEPTH,
    parameter int AT_THR   = DEF_AT_THR,
    parameter int SLEW_MAX = DEF_SLEW_MAX
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving,
    input  logic [HDNG_W-1:0]       dsrd_hdng,
    input  logic [HDNG_W-1:0]       actl_hdng,
    input  logic                    hdng_vld,
    input  logic [SPD_W-1:0]        frwrd_spd,
    input  logic [3:0]              p_coeff,
    input  logic [4:0]              d_coeff,
    output logic                    at_hdng,
    output logic                    out_vld,
    output logic signed [OUT_W-1:0] lft_spd,
    output logic signed [OUT_W-1:0] rght_spd
);

    logic signed [HDNG_W-1:0] err_raw;
    logic signed [ERR_W-1:0]  err_d;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [ERR_W+5:0]  i_term;
    logic signed [ERR_W-1:0]  hist_q [D_DEPTH];
    logic signed [ERR_W:0]    diff;
    logic signed [31:0]       diff_sat;
    logic signed [31:0]       p_term;
    logic signed [31:0]       d_term;
    logic signed [31:0]       sum;
    logic signed [31:0]       target;
    logic signed [OUT_W-1:0]  pid_d;
    logic signed [OUT_W-1:0]  pid_q;
    logic                     out_vld_q;
    logic signed [31:0]       spd_ext;
    logic signed [31:0]       err_mag;

    // Heading difference wraps modulo 2^HDNG_W, then clamps into ERR_W.
    assign err_raw = $signed(actl_hdng - dsrd_hdng);
    assign err_d   = ERR_W'(sat_s(32'(err_raw), ERR_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= '0;
            pid_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            pid_q     <= pid_d;
            out_vld_q <= hdng_vld;
        end
    end

    pid_hdng_integ #(
        .ERR_W   (ERR_W),
        .I_SHIFT (I_SHIFT)
    ) u_integ (
        .clk        (clk),
        .rst_n      (rst_n),
        .moving_i   (moving),
        .hdng_vld_i (hdng_vld),
        .err_i      (err_q),
        .i_term_o   (i_term)
    );

    // History is deliberately independent of moving so D stays continuous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < D_DEPTH; k++)
                hist_q[k] <= '0;
        end else if (hdng_vld) begin
            hist_q[0] <= err_q;
            for (int k = 1; k < D_DEPTH; k++)
                hist_q[k] <= hist_q[k-1];
        end
    end

    assign diff     = (ERR_W+1)'(err_q) - (ERR_W+1)'(hist_q[D_DEPTH-1]);
    assign diff_sat = sat_s(32'(diff), 8);

    assign p_term = 32'($signed({1'b0, p_coeff})) * 32'(err_q);
    assign d_term = diff_sat * 32'($signed({1'b0, d_coeff}));
    assign sum    = p_term + 32'(i_term) + d_term;
    assign target = sat_s(sum >>> OUT_SHIFT, OUT_W);

`ifdef PID_HDNG_SLEW_EN
    logic signed [31:0] step;

    always_comb begin
        step  = target - 32'(pid_q);
        pid_d = OUT_W'(target);
        if (!moving)
            pid_d = '0;
        else if (step > SLEW_MAX)
            pid_d = OUT_W'(32'(pid_q) + SLEW_MAX);
        else if (step < -SLEW_MAX)
            pid_d = OUT_W'(32'(pid_q) - SLEW_MAX);
    end
`else
    assign pid_d = OUT_W'(target);
`endif

    // Forward speed is unsigned; zero-extend before mixing with the signed PID.
    assign spd_ext  = 32'(frwrd_spd);
    assign lft_spd  = moving ? OUT_W'(sat_s(spd_ext + 32'(pid_q), OUT_W)) : '0;
    assign rght_spd = moving ? OUT_W'(sat_s(spd_ext - 32'(pid_q), OUT_W)) : '0;

    assign err_mag = err_q[ERR_W-1] ? -32'(err_q) : 32'(err_q);
    assign at_hdng = err_mag < AT_THR;
    assign out_vld = out_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_pid_hdng_ctrl.sv
// tb_pid_hdng_ctrl: scoreboard bench for pid_hdng_ctrl (default parameters).
`default_nettype none

module tb_pid_hdng_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        moving;
    logic [11:0] dsrd_hdng;
    logic [11:0] actl_hdng;
    logic        hdng_vld;
    logic [10:0] frwrd_spd;
    logic [3:0]  p_coeff;
    logic [4:0]  d_coeff;
    logic        at_hdng;
    logic        out_vld;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;

    pid_hdng_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .moving    (moving),
        .dsrd_hdng (dsrd_hdng),
        .actl_hdng (actl_hdng),
        .hdng_vld  (hdng_vld),
        .frwrd_spd (frwrd_spd),
        .p_coeff   (p_coeff),
        .d_coeff   (d_coeff),
        .at_hdng   (at_hdng),
        .out_vld   (out_vld),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [11:0] lft;
        logic [11:0] rght;
        logic        at;
        logic        vld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string n, input int l, input int r, input logic a, input logic v);
        exp_t e;
        e.name = n;
        e.lft  = 12'(l);
        e.rght = 12'(r);
        e.at   = a;
        e.vld  = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hdng(input int actl, input int dsrd);
        actl_hdng = 12'(actl);
        dsrd_hdng = 12'(dsrd);
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n = 1'b0; moving = 1'b0; hdng_vld = 1'b0;
        set_hdng(0, 0);
        frwrd_spd = '0; p_coeff = '0; d_coeff = '0;
        push("reset", 0, 0, 1'b1, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        e = sb.pop_front();
        checks++;
        if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
            errors++;
            $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                     e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
        end
    endtask

    task automatic test_prop;
        exp_t e;
        moving = 1'b1; p_coeff = 4'd3; d_coeff = '0; frwrd_spd = '0;
        set_hdng(12'h400, 0);
        push("prop_lat1", 0, 0, 1'b0, 1'b0);
`ifdef PID_HDNG_SLEW_EN
        push("prop_lat2", 16, -16, 1'b0, 1'b0);
`else
        push("prop_lat2", 191, -191, 1'b0, 1'b0);
`endif
        push("prop_settled", 191, -191, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(k == 2 ? 20 : 1);
            e = sb.pop_front();
            checks++;
            if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
                errors++;
                $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                         e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
            end
        end
    endtask

    task automatic test_clamp;
        exp_t e;
        frwrd_spd = 11'd2047;
        push("clamp_pos", 2047, 1856, 1'b0, 1'b0);
        set_hdng(0, 12'h400);
        push("prop_neg_sat", 2047 - 192, 2047, 1'b0, 1'b0);
        tick(1);
        e = sb.pop_front();
        checks++;
        if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
            errors++;
            $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                     e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
        end
        frwrd_spd = '0;
        push("prop_neg", -192, 192, 1'b0, 1'b0);
        tick(20);
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            checks++;
            if (k == 0) begin
                frwrd_spd = 11'd2047;
                #1;
            end else begin
                frwrd_spd = '0;
                #1;
            end
            if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
                errors++;
                $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                         e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
            end
        end
    endtask

    task automatic test_integral;
        exp_t e;
        moving = 1'b0; p_coeff = '0; d_coeff = '0; frwrd_spd = '0;
        set_hdng(0, 0);
        tick(3);
        moving = 1'b1;
        set_hdng(16, 0);
        tick(1);
        hdng_vld = 1'b1;
        tick(64);
        push("integ_63", 7, -7, 1'b1, 1'b1);
        push("integ_64", 8, -8, 1'b1, 1'b0);
        push("integ_clear", 0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                hdng_vld = 1'b0;
                tick(1);
            end else if (k == 2) begin
                moving = 1'b0;
                tick(2);
                moving = 1'b1;
                #1;
            end
            e = sb.pop_front();
            checks++;
            if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
                errors++;
                $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                         e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
            end
        end
    endtask

    task automatic test_threshold;
        exp_t e;
        int   errs [6];
        errs = '{29, 30, -29, -30, 0, -2048};
        moving = 1'b0;
        tick(1);
        moving = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (errs[k] < 0)
                set_hdng(0, -errs[k]);
            else
                set_hdng(errs[k], 0);
            push($sformatf("thresh_%0d", errs[k]), 0, 0,
                 (errs[k] < 30 && errs[k] > -30) ? 1'b1 : 1'b0, 1'b0);
            tick(1);
            e = sb.pop_front();
            checks++;
            if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
                errors++;
                $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                         e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
            end
        end
    endtask

    task automatic test_deriv;
        exp_t e;
        int   steps [2];
        steps = '{100, 200};
        moving = 1'b0; p_coeff = '0; d_coeff = '0;
        set_hdng(0, 0);
        tick(1);
        hdng_vld = 1'b1;
        tick(2);
        hdng_vld = 1'b0;
        moving = 1'b1; d_coeff = 5'd8;
        for (int k = 0; k < 2; k++) begin
            set_hdng(steps[k], 0);
            // D = min(err,127) * 8, then scaled by 1/8
            push($sformatf("deriv_%0d", steps[k]), steps[k] > 127 ? 127 : steps[k],
                 steps[k] > 127 ? -127 : -steps[k], 1'b0, 1'b0);
            tick(12);
            e = sb.pop_front();
            checks++;
            if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
                errors++;
                $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                         e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
            end
        end
    endtask

    task automatic test_slew;
        exp_t e;
        int   n;
        moving = 1'b0; p_coeff = 4'd3; d_coeff = '0; frwrd_spd = '0;
        set_hdng(0, 0);
        tick(3);
        moving = 1'b1;
        set_hdng(12'h400, 0);
        tick(1);
`ifdef PID_HDNG_SLEW_EN
        for (int k = 1; k <= 11; k++)
            push($sformatf("slew_step%0d", k), 16 * k, -16 * k, 1'b0, 1'b0);
        push("slew_step12", 191, -191, 1'b0, 1'b0);
`else
        push("slew_off_step1", 191, -191, 1'b0, 1'b0);
`endif
        n = sb.size();
        for (int k = 0; k < n; k++) begin
            tick(1);
            e = sb.pop_front();
            checks++;
            if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
                errors++;
                $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                         e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        push("pre_reset", 191, -191, 1'b0, 1'b0);
        push("async_reset", 0, 0, 1'b1, 1'b0);
        tick(20);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                #2 rst_n = 1'b0;
                #1;
            end
            e = sb.pop_front();
            checks++;
            if ({lft_spd, rght_spd, at_hdng, out_vld} !== {e.lft, e.rght, e.at, e.vld}) begin
                errors++;
                $display("FAIL %s: got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                         e.name, lft_spd, rght_spd, at_hdng, out_vld, $signed(e.lft), $signed(e.rght), e.at, e.vld);
            end
        end
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_prop();
        test_clamp();
        test_integral();
        test_threshold();
        test_deriv();
        test_slew();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion exp finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
